// File: rtl/rr_encoder_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant and 2-bit encoded index.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_encoder_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] last;
    logic [1:0] last_nxt;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       found;
    logic       rel;
    logic       force_rel;
    logic [3:0] gnt_nxt;
    logic [1:0] idx_nxt;
    logic       vld_nxt;

    generate
        if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold_max
            $error("HOLD_MAX must be in 2..256");
        end
    endgenerate

    // Circular search starting just after the last winner; offset 4 wraps back to last itself.
    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign rel = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    logic [CW-1:0] hold_cnt;
    logic          timeout_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + CW'(1);
            end
        end else begin
            hold_cnt <= '0;
        end
    end

    assign force_rel = (hold_cnt == HOLD_LAST);
    // A normal release on the same cycle wins, so no pulse is raised then.
    assign timeout_nxt = (state == GRANT) & force_rel & ~rel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= timeout_nxt;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        vld_nxt   = gnt_valid;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt   = 4'b0001 << pick;
                    idx_nxt   = pick;
                    vld_nxt   = 1'b1;
                    last_nxt  = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // gnt_idx is left as-is so the steered datapath keeps a stable select.
                if (rel || force_rel) begin
                    gnt_nxt   = 4'b0000;
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 2'd3;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Scoreboard bench for rr_encoder_arbiter: driver queues expected outputs, monitor compares.
// Build with ARB_TIMEOUT_EN defined to exercise forced release (HOLD_MAX=4).
module tb_rr_encoder_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_encoder_arbiter #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {gnt[3:0], gnt_idx[1:0], gnt_valid, timeout}
    logic [7:0] exp_q[$];
    int         n_chk   = 0;
    int         n_fail  = 0;
    int         step_no = 0;
    logic       imm_req = 1'b0;
    logic [7:0] imm_exp = 8'h00;

    always @(negedge clk or posedge imm_req) begin
        logic [7:0] act;
        logic [7:0] e;
        act = {gnt, gnt_idx, gnt_valid, timeout};
        if (imm_req) begin
            n_chk++;
            if (act !== imm_exp) begin
                n_fail++;
                $display("FAIL async_reset_clear: got gnt=%b idx=%b vld=%b to=%b, expected gnt=%b idx=%b vld=%b to=%b",
                         act[7:4], act[3:2], act[1], act[0],
                         imm_exp[7:4], imm_exp[3:2], imm_exp[1], imm_exp[0]);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step_no++;
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL step%0d: got gnt=%b idx=%b vld=%b to=%b, expected gnt=%b idx=%b vld=%b to=%b",
                         step_no, act[7:4], act[3:2], act[1], act[0],
                         e[7:4], e[3:2], e[1], e[0]);
            end
        end
    end

    // Apply inputs for one cycle and queue the outputs expected after the next rising edge.
    task automatic step(input logic [3:0] r, input logic d,
                        input logic [3:0] eg, input logic [1:0] ei,
                        input logic ev, input logic et);
        @(negedge clk);
        #1;
        req  = r;
        done = d;
        exp_q.push_back({eg, ei, ev, et});
    endtask

    localparam logic TO_BUILD =
`ifdef ARB_TIMEOUT_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;

        // Reset held across two edges with all requests asserted
        step(4'b1111, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // First grant after reset goes to requester 0, then rotation 1,2,3
        step(4'b1111, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b0);

        // Skip and fairness with requesters 1 and 3 only (LAST=3)
        step(4'b1010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        step(4'b1010, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0);

        // Idle with no requests; DONE ignored, index holds
        step(4'b0000, 1'b1, 4'b0000, 2'b01, 1'b0, 1'b0);

        // Single request (DONE ignored in idle), other requests ignored while granted, drop releases
        step(4'b0100, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0);
        step(4'b1011, 1'b0, 4'b0000, 2'b10, 1'b0, 1'b0);

        // DONE on the saturating cycle is a normal release: no timeout pulse
        step(4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        end
        step(4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);

        // Long hold: forced release every 5 cycles with the macro, indefinite hold without
        step(4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            if (TO_BUILD && (i % 5) == 4) begin
                step(4'b0001, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b1);
            end else begin
                step(4'b0001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
            end
        end
        step(4'b0001, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);

        // Async reset in the middle of a grant to requester 3
        step(4'b1000, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        imm_exp = 8'h00;
        imm_req = 1'b1;
        #1;
        imm_req = 1'b0;
        rst_n   = 1'b1;
        req     = 4'b1001;

        // LAST is back to 3, so requester 0 wins
        step(4'b1001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b1001, 1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
